// File: rtl/ram_ctrl_if.sv
// Bus bundle between the core pipeline, ram_ctrl and the synchronous single-port RAM.
// The master side is the pipeline/RAM environment; the slave side is the controller.
interface ram_ctrl_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_ack;
    logic [XLEN-1:0] i_rdata;

    logic            d_req;
    logic            d_we;
    logic [2:0]      d_size;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ack;
    logic [XLEN-1:0] d_rdata;
    logic            d_err;

    logic            ramR;
    logic            ramW;
    logic [XLEN-1:0] ram_addr;
    logic [XLEN-1:0] ram_dataW;
    logic [XLEN-1:0] ram_dataR;

    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_dataR,
        input  i_ack, i_rdata, d_ack, d_rdata, d_err, ramR, ramW, ram_addr, ram_dataW
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_dataR,
        output i_ack, i_rdata, d_ack, d_rdata, d_err, ramR, ramW, ram_addr, ram_dataW
    );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-owner sequencer for the shared instruction/data RAM, with sub-word
// load extraction and read-modify-write sub-word stores. Define RAM_CTRL_MISALIGN_EN to trap misaligned data accesses.
module ram_ctrl #(
    parameter int DEPTH_LOG2 = 5,
    parameter int XLEN       = 32
) (
    input logic       clock,
    input logic       nReset,
    ram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_RESP = 2'd1,
        ST_RMW_WR  = 2'd2,
        ST_WR_ACK  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SZ_B  = 3'd0,
        SZ_H  = 3'd1,
        SZ_W  = 3'd2,
        SZ_BU = 3'd3,
        SZ_HU = 3'd4
    } size_e;

    function automatic size_e decode_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            3'b000:  sz = SZ_B;
            3'b001:  sz = SZ_H;
            3'b100:  sz = SZ_BU;
            3'b101:  sz = SZ_HU;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic [XLEN-1:0] extract_load(input size_e sz, input logic [1:0] lane,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    r = {{(XLEN-8){b[7]}}, b};
            SZ_H:    r = {{(XLEN-16){h[15]}}, h};
            SZ_BU:   r = {{(XLEN-8){1'b0}}, b};
            SZ_HU:   r = {{(XLEN-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] merge_store(input logic half, input logic [1:0] lane,
                                                    input logic [XLEN-1:0] old,
                                                    input logic [15:0] wd);
        logic [XLEN-1:0] r;
        r = old;
        if (half) begin
            if (lane[1]) begin
                r[31:16] = wd;
            end else begin
                r[15:0] = wd;
            end
        end else begin
            r[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return r;
    endfunction

    state_e                state_q;
    logic                  owner_data_q;
    size_e                 size_q;
    logic [1:0]            lane_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [15:0]           wdata_q;
    logic                  i_ack_q;
    logic                  d_ack_q;
    logic                  d_err_q;
    logic [XLEN-1:0]       i_rdata_q;
    logic [XLEN-1:0]       d_rdata_q;

    size_e                 d_size_s;
    logic                  d_sub_s;
    logic                  d_misalign_s;
    logic [DEPTH_LOG2-1:0] d_idx_s;
    logic [DEPTH_LOG2-1:0] i_idx_s;
    logic [XLEN-1:0]       load_word_s;
    logic                  ramR_s;
    logic                  ramW_s;
    logic [DEPTH_LOG2-1:0] ram_idx_s;
    logic [XLEN-1:0]       ram_dataW_s;
    logic                  unused_s;

    assign d_size_s    = decode_size(bus.d_size);
    assign d_sub_s     = (d_size_s != SZ_W);
    assign d_idx_s     = bus.d_addr[DEPTH_LOG2+1:2];
    assign i_idx_s     = bus.i_addr[DEPTH_LOG2+1:2];
    assign load_word_s = extract_load(size_q, lane_q, bus.ram_dataR);

`ifdef RAM_CTRL_MISALIGN_EN
    assign d_misalign_s = ((d_size_s == SZ_H || d_size_s == SZ_HU) && bus.d_addr[0]) ||
                          ((d_size_s == SZ_W) && (bus.d_addr[1:0] != 2'b00));
`else
    assign d_misalign_s = 1'b0;
`endif

    // Address bits above the RAM depth alias; fetches are always word-aligned.
    assign unused_s = ^{bus.i_addr[XLEN-1:DEPTH_LOG2+2], bus.i_addr[1:0],
                        bus.d_addr[XLEN-1:DEPTH_LOG2+2]};

    // RAM strobes are decoded from the current state so a grant reaches the RAM in its own cycle.
    always_comb begin
        ramR_s      = 1'b0;
        ramW_s      = 1'b0;
        ram_idx_s   = idx_q;
        ram_dataW_s = {XLEN{1'b0}};
        if (!nReset) begin
            ramR_s = 1'b0;
            ramW_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.d_req) begin
                        ram_idx_s = d_idx_s;
                        if (d_misalign_s) begin
                            ramR_s = 1'b0;
                        end else if (!bus.d_we || d_sub_s) begin
                            ramR_s = 1'b1;
                        end else begin
                            ramW_s      = 1'b1;
                            ram_dataW_s = bus.d_wdata;
                        end
                    end else if (bus.i_req) begin
                        ram_idx_s = i_idx_s;
                        ramR_s    = 1'b1;
                    end else begin
                        ramR_s = 1'b0;
                    end
                end
                ST_RMW_WR: begin
                    ramW_s      = 1'b1;
                    ram_dataW_s = merge_store((size_q == SZ_H || size_q == SZ_HU), lane_q,
                                              bus.ram_dataR, wdata_q);
                end
                default: begin
                    ramR_s = 1'b0;
                    ramW_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer: grant in IDLE with data priority, then respond and return to IDLE.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            owner_data_q <= 1'b0;
            size_q       <= SZ_W;
            lane_q       <= 2'b00;
            idx_q        <= {DEPTH_LOG2{1'b0}};
            wdata_q      <= 16'h0000;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= {XLEN{1'b0}};
            d_rdata_q    <= {XLEN{1'b0}};
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            d_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.d_req) begin
                        owner_data_q <= 1'b1;
                        size_q       <= d_size_s;
                        lane_q       <= bus.d_addr[1:0];
                        idx_q        <= d_idx_s;
                        wdata_q      <= bus.d_wdata[15:0];
                        if (d_misalign_s) begin
                            state_q   <= ST_WR_ACK;
                            d_ack_q   <= 1'b1;
                            d_err_q   <= 1'b1;
                            d_rdata_q <= {XLEN{1'b0}};
                        end else if (!bus.d_we) begin
                            state_q <= ST_RD_RESP;
                            d_ack_q <= 1'b1;
                        end else if (d_sub_s) begin
                            state_q <= ST_RMW_WR;
                        end else begin
                            state_q <= ST_WR_ACK;
                            d_ack_q <= 1'b1;
                        end
                    end else if (bus.i_req) begin
                        owner_data_q <= 1'b0;
                        idx_q        <= i_idx_s;
                        state_q      <= ST_RD_RESP;
                        i_ack_q      <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_RESP: begin
                    state_q <= ST_IDLE;
                    if (owner_data_q) begin
                        d_rdata_q <= load_word_s;
                    end else begin
                        i_rdata_q <= bus.ram_dataR;
                    end
                end
                ST_RMW_WR: begin
                    state_q <= ST_WR_ACK;
                    d_ack_q <= 1'b1;
                end
                ST_WR_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data arrives from the RAM during the ack cycle, so it bypasses the holding register then.
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.i_rdata   = (state_q == ST_RD_RESP && !owner_data_q) ? bus.ram_dataR : i_rdata_q;
    assign bus.d_rdata   = (state_q == ST_RD_RESP && owner_data_q) ? load_word_s : d_rdata_q;
    assign bus.ramR      = ramR_s;
    assign bus.ramW      = ramW_s;
    assign bus.ram_addr  = {{(XLEN-DEPTH_LOG2){1'b0}}, ram_idx_s};
    assign bus.ram_dataW = ram_dataW_s;
endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed scenarios plus randomized traffic checked
// against a byte-addressed memory reference model.
module tb_ram_ctrl;
    localparam int DEPTH_LOG2 = 5;
    localparam int XLEN       = 32;
    localparam int WORDS      = 32;

    logic        clock  = 1'b0;
    logic        nReset = 1'b0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    ram_ctrl_if #(.XLEN(XLEN)) bus ();

    ram_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .XLEN(XLEN)) dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM with registered read data.
    always @(posedge clock) begin
        if (bus.ramW) mem[bus.ram_addr[4:0]] <= bus.ram_dataW;
        if (bus.ramR) bus.ram_dataR <= mem[bus.ram_addr[4:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        #2;
        check("ram_rw_excl", {31'd0, bus.ramR & bus.ramW}, 32'd0);
    end

    function automatic logic is_w(input logic [2:0] f3);
        return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef RAM_CTRL_MISALIGN_EN
        if (f3 == 3'd1 || f3 == 3'd5) return (addr % 32'd2) != 32'd0;
        if (is_w(f3)) return (addr % 32'd4) != 32'd0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] word;
        logic [31:0] off;
        logic [31:0] v;
        word = ref_mem[addr[6:2]];
        off  = addr % 32'd4;
        case (f3)
            3'd0, 3'd4: v = (word >> (32'd8 * off)) & 32'h0000_00FF;
            3'd1, 3'd5: v = (word >> (32'd16 * (off / 32'd2))) & 32'h0000_FFFF;
            default:    return word;
        endcase
        if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
        if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] sh;
        logic [31:0] mask;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            sh   = 32'd8 * (addr % 32'd4);
            mask = 32'h0000_00FF << sh;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            sh   = 32'd16 * ((addr % 32'd4) / 32'd2);
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh   = 32'd0;
            mask = 32'hFFFF_FFFF;
        end
        ref_mem[addr[6:2]] = (ref_mem[addr[6:2]] & ~mask) | ((wd << sh) & mask);
    endtask

    task automatic do_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err,
                           output int lat);
        logic misal;
        logic exp_r;
        logic exp_w;
        misal = ref_misaligned(f3, addr);
        exp_r = !misal && (!we || !is_w(f3));
        exp_w = !misal && we && is_w(f3);
        @(negedge clock);
        check("ack_idle", {30'd0, bus.d_ack, bus.i_ack}, 32'd0);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_size  = f3;
        bus.d_addr  = addr;
        bus.d_wdata = wd;
        #1;
        check("grant_ramR", {31'd0, bus.ramR}, {31'd0, exp_r});
        check("grant_ramW", {31'd0, bus.ramW}, {31'd0, exp_w});
        if (exp_r || exp_w) check("grant_addr", bus.ram_addr, {27'd0, addr[6:2]});
        if (exp_w) check("grant_dataW", bus.ram_dataW, wd);
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1 && we && !is_w(f3) && !misal) check("rmw_ramW", {31'd0, bus.ramW}, 32'd1);
            if (bus.d_ack) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check("d_ack_timeout", 32'd0, 32'd1);
        rd = bus.d_rdata;
        err = bus.d_err;
        bus.d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] rd, output int lat);
        @(negedge clock);
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (bus.i_ack) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check("i_ack_timeout", 32'd0, 32'd1);
        rd = bus.i_rdata;
        bus.i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] frd;
        logic [31:0] wd;
        logic [31:0] addr;
        logic [31:0] pre;
        logic [31:0] exp;
        logic [31:0] last_fetch;
        logic [31:0] last_load;
        logic [2:0]  f3;
        logic        err;
        logic        misal;
        int          lat;
        int          flat;
        int          op;
        int          exp_lat;

        bus.i_req = 1'b0; bus.i_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 3'd2;
        bus.d_addr = 32'd0; bus.d_wdata = 32'd0; bus.ram_dataR = 32'd0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        // Reset with requests pending: strobes must stay low.
        nReset = 1'b0;
        bus.d_req = 1'b1;
        bus.i_req = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_ramR", {31'd0, bus.ramR}, 32'd0);
        check("rst_ramW", {31'd0, bus.ramW}, 32'd0);
        check("rst_acks", {29'd0, bus.i_ack, bus.d_ack, bus.d_err}, 32'd0);
        check("rst_i_rdata", bus.i_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        @(negedge clock);
        nReset = 1'b1;

        do_data(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, rd, err, lat);
        ref_store(3'b010, 32'h8, 32'hDEADBEEF);
        check("sw_lat", lat, 32'd1);
        do_data(1'b0, 3'b010, 32'h8, 32'd0, rd, err, lat);
        check("lw_lat", lat, 32'd1);
        check("lw_data", rd, 32'hDEADBEEF);
        check("lw_err", {31'd0, err}, 32'd0);

        do_data(1'b1, 3'b000, 32'h9, 32'h000000AA, rd, err, lat);
        ref_store(3'b000, 32'h9, 32'h000000AA);
        check("sb_lat", lat, 32'd2);
        do_data(1'b0, 3'b010, 32'h8, 32'd0, rd, err, lat);
        check("sb_merge", rd, 32'hDEADAAEF);
        do_data(1'b0, 3'b000, 32'hB, 32'd0, rd, err, lat);
        check("lb_sext", rd, 32'hFFFFFFDE);
        do_data(1'b0, 3'b100, 32'hB, 32'd0, rd, err, lat);
        check("lbu_zext", rd, 32'h000000DE);
        do_data(1'b0, 3'b001, 32'hA, 32'd0, rd, err, lat);
        check("lh_sext", rd, 32'hFFFFDEAD);

        // Simultaneous requests: data wins, fetch waits and is not lost.
        fork
            do_data(1'b0, 3'b010, 32'h8, 32'd0, rd, err, lat);
            do_fetch(32'h10, frd, flat);
        join
        check("race_d_lat", lat, 32'd1);
        check("race_d_data", rd, 32'hDEADAAEF);
        check("race_i_lat", flat, 32'd3);
        check("race_i_data", frd, ref_mem[4]);

        // Reset while the sub-word store is in its write cycle.
        pre = ref_mem[0];
        @(negedge clock);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 3'b000;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h55;
        @(negedge clock);
        check("rmw_pre_rst_ramW", {31'd0, bus.ramW}, 32'd1);
        nReset = 1'b0;
        #1;
        check("rst_rmw_ramW", {31'd0, bus.ramW}, 32'd0);
        @(negedge clock);
        bus.d_req = 1'b0;
        check("rst_rmw_no_ack", {31'd0, bus.d_ack}, 32'd0);
        check("rst_rmw_i_rdata", bus.i_rdata, 32'd0);
        check("rst_rmw_d_rdata", bus.d_rdata, 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        check("rst_rmw_no_ack2", {31'd0, bus.d_ack}, 32'd0);
        do_data(1'b0, 3'b010, 32'h0, 32'd0, rd, err, lat);
        check("rst_rmw_mem_kept", rd, pre);
        last_fetch = 32'd0;

        do_data(1'b0, 3'b010, 32'h6, 32'd0, rd, err, lat);
        check("lw6_lat", lat, 32'd1);
`ifdef RAM_CTRL_MISALIGN_EN
        check("lw6_err", {31'd0, err}, 32'd1);
        check("lw6_data", rd, 32'd0);
        last_load = 32'd0;
`else
        check("lw6_err", {31'd0, err}, 32'd0);
        check("lw6_data", rd, ref_mem[1]);
        last_load = ref_mem[1];
`endif

        for (int k = 0; k < 90; k++) begin
            op   = $urandom_range(0, 3);
            addr = $urandom;
            if (op == 0) begin
                do_fetch(addr, rd, lat);
                check("fetch_lat", lat, 32'd1);
                check("fetch_data", rd, ref_mem[addr[6:2]]);
                check("d_rdata_hold", bus.d_rdata, last_load);
                last_fetch = ref_mem[addr[6:2]];
            end else if (op == 1) begin
                f3 = 3'($urandom_range(0, 2));
                wd = $urandom;
                misal = ref_misaligned(f3, addr);
                do_data(1'b1, f3, addr, wd, rd, err, lat);
                exp_lat = (!misal && !is_w(f3)) ? 2 : 1;
                check("st_lat", lat, exp_lat);
                check("st_err", {31'd0, err}, {31'd0, misal});
                check("i_rdata_hold", bus.i_rdata, last_fetch);
                if (misal) begin
                    check("st_err_rdata", rd, 32'd0);
                    last_load = 32'd0;
                end else begin
                    ref_store(f3, addr, wd);
                end
            end else begin
                f3 = 3'($urandom_range(0, 7));
                misal = ref_misaligned(f3, addr);
                exp = misal ? 32'd0 : ref_load(f3, addr);
                do_data(1'b0, f3, addr, 32'd0, rd, err, lat);
                check("ld_lat", lat, 32'd1);
                check("ld_data", rd, exp);
                check("ld_err", {31'd0, err}, {31'd0, misal});
                check("i_rdata_hold", bus.i_rdata, last_fetch);
                last_load = exp;
            end
        end

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
